// File: rtl/rs232_mem_burst_if.sv
// Command, write-beat and read-beat streams of the burst RAM controller.
// The master side issues commands and write beats; the slave side is the controller.
interface rs232_mem_burst_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data;
  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic              busy;
  logic              wrap;
  logic              err;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready,
    input  cmd_ready, wr_ready, rd_valid, rd_data, busy, wrap, err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready,
    output cmd_ready, wr_ready, rd_valid, rd_data, busy, wrap, err
  );
endinterface

// File: rtl/rs232_mem_burst.sv
// Single-port RAM with a write/read/clear burst controller; address auto-increments
// modulo DEPTH and both data streams may stall at any beat.
module rs232_mem_burst #(
  parameter int                ADDR_W = 14,
  parameter int                DATA_W = 8,
  parameter int                LEN_W  = 8,
  parameter logic [DATA_W-1:0] FILL   = '0
) (
  input logic               clk,
  input logic               rst,
  rs232_mem_burst_if.slave  bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_READ  = 2'd2;
  localparam logic [1:0] S_CLEAR = 2'd3;

  logic [1:0]        state;
  logic [ADDR_W-1:0] addr;
  logic [LEN_W-1:0]  cnt;
  logic              rd_done;
  logic              rd_vld_p1;
  logic [DATA_W-1:0] rd_data_p1;
  logic              wrap_q;
  logic              err_q;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              accept;
  logic              wr_hs;
  logic              rd_issue;
  logic              advance;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;

  assign bus.cmd_ready = (state == S_IDLE) && !rd_vld_p1;
  assign accept        = bus.cmd_valid && bus.cmd_ready;
  assign wr_hs         = (state == S_WRITE) && bus.wr_valid;
  // rd_done marks that the last beat has already been issued; only its drain remains
  assign rd_issue      = (state == S_READ) && !rd_done && (!rd_vld_p1 || bus.rd_ready);
  assign advance       = wr_hs || (state == S_CLEAR) || rd_issue;
  assign mem_we        = wr_hs || (state == S_CLEAR);
  assign mem_wdata     = (state == S_CLEAR) ? FILL : bus.wr_data;

  assign bus.wr_ready  = (state == S_WRITE);
  assign bus.rd_valid  = rd_vld_p1;
  assign bus.rd_data   = rd_data_p1;
  assign bus.busy      = (state != S_IDLE);
  assign bus.wrap      = wrap_q;
  assign bus.err       = err_q;

  always_ff @(posedge clk) begin
    if (mem_we) mem[addr] <= mem_wdata;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      addr <= bus.cmd_addr;
      cnt  <= bus.cmd_len;
    end else if (advance) begin
      addr <= addr + 1'b1;
      cnt  <= cnt - 1'b1;
    end
  end

  // Stage p1: registered read data with its valid, plus burst control
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      rd_done    <= 1'b0;
      rd_vld_p1  <= 1'b0;
      rd_data_p1 <= '0;
      wrap_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      err_q <= accept && (bus.cmd_op == 2'b11);
      if (advance && (addr == '1)) wrap_q <= 1'b1;
      case (state)
        S_IDLE: begin
          if (accept) begin
            wrap_q  <= 1'b0;
            rd_done <= 1'b0;
            case (bus.cmd_op)
              2'b00:   state <= S_READ;
              2'b01:   state <= S_WRITE;
              2'b10:   state <= S_CLEAR;
              default: state <= S_IDLE;
            endcase
          end
        end
        S_WRITE: begin
          if (wr_hs && (cnt == '0)) state <= S_IDLE;
        end
        S_CLEAR: begin
          if (cnt == '0) state <= S_IDLE;
        end
        S_READ: begin
          if (rd_issue) begin
            rd_vld_p1  <= 1'b1;
            rd_data_p1 <= mem[addr];
            if (cnt == '0) rd_done <= 1'b1;
          end else if (rd_vld_p1 && bus.rd_ready) begin
            rd_vld_p1 <= 1'b0;
            if (rd_done) state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rs232_mem_burst.sv
// Directed bench for rs232_mem_burst: reset, bursts, address wrap, stalls, clear, illegal ops.
module tb_rs232_mem_burst;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  logic [7:0] rbuf [0:255];

  always #5 clk = ~clk;

  rs232_mem_burst_if #(.ADDR_W(14), .DATA_W(8), .LEN_W(8)) bus ();

  rs232_mem_burst #(.ADDR_W(14), .DATA_W(8), .LEN_W(8), .FILL(8'h00)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Drivers: all return on a falling edge
  task automatic do_cmd(input logic [1:0] op, input logic [13:0] a, input logic [7:0] len);
    int t = 0;
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_addr = a; bus.cmd_len = len;
    while (!bus.cmd_ready && t < 1000) begin @(negedge clk); t++; end
    if (!bus.cmd_ready) begin
      checks++; failures++;
      $display("FAIL cmd_accept_timeout ready=%0b required=1", bus.cmd_ready);
    end
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic write_beats(input int n, input logic [7:0] d0, input int gap);
    for (int i = 0; i < n; i++) begin
      bus.wr_valid = 1'b0;
      for (int g = 0; g < gap; g++) @(negedge clk);
      bus.wr_valid = 1'b1;
      bus.wr_data  = d0 + 8'(i);
      for (int t = 0; t < 100 && !bus.wr_ready; t++) @(negedge clk);
      if (!bus.wr_ready) begin
        checks++; failures++;
        $display("FAIL wr_ready_timeout beat=%0d ready=0 required=1", i);
      end
      @(negedge clk);
    end
    bus.wr_valid = 1'b0;
  endtask

  task automatic write_burst(input logic [13:0] a, input int n, input logic [7:0] d0);
    do_cmd(2'b01, a, 8'(n - 1));
    write_beats(n, d0, 0);
  endtask

  // mode 0: rd_ready always 1; mode 1: rd_ready pattern 1,0,0 repeating
  task automatic read_burst(input logic [13:0] a, input int n, input int mode);
    int got = 0;
    int cyc = 0;
    logic held = 1'b0;
    logic [7:0] hv = '0;
    do_cmd(2'b00, a, 8'(n - 1));
    while (got < n && cyc < 3000) begin
      if (held) begin
        checks++;
        if (bus.rd_valid !== 1'b1 || bus.rd_data !== hv) begin
          failures++;
          $display("FAIL rd_stall_stable vld=%0b data=%02h required vld=1 data=%02h", bus.rd_valid, bus.rd_data, hv);
        end
      end
      bus.rd_ready = (mode == 0) ? 1'b1 : (cyc % 3 == 0);
      if (bus.rd_valid && bus.rd_ready) begin
        rbuf[got] = bus.rd_data; got++; held = 1'b0;
      end else if (bus.rd_valid) begin
        held = 1'b1; hv = bus.rd_data;
      end
      @(negedge clk); cyc++;
    end
    bus.rd_ready = 1'b0;
    if (got < n) begin
      checks++; failures++;
      $display("FAIL rd_timeout beats=%0d required=%0d", got, n);
    end
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({bus.cmd_ready, bus.wr_ready, bus.rd_valid, bus.rd_data, bus.busy, bus.wrap, bus.err} !== {3'b100, 8'h00, 3'b000}) begin
      failures++;
      $display("FAIL powerup_reset outs=%b required=%b",
        {bus.cmd_ready, bus.wr_ready, bus.rd_valid, bus.rd_data, bus.busy, bus.wrap, bus.err}, {3'b100, 8'h00, 3'b000});
    end
    @(negedge clk); rst = 1'b1;
    write_burst(14'h0020, 8, 8'h50);
    read_burst(14'h0020, 8, 0);
    do_cmd(2'b01, 14'h0020, 8'd7);
    write_beats(3, 8'hC0, 0);
    bus.wr_valid = 1'b1; bus.wr_data = 8'hFF;
    rst = 1'b0;
    #1;
    checks++;
    if ({bus.cmd_ready, bus.wr_ready, bus.rd_valid, bus.rd_data, bus.busy, bus.wrap, bus.err} !== {3'b100, 8'h00, 3'b000}) begin
      failures++;
      $display("FAIL midburst_reset outs=%b required=%b",
        {bus.cmd_ready, bus.wr_ready, bus.rd_valid, bus.rd_data, bus.busy, bus.wrap, bus.err}, {3'b100, 8'h00, 3'b000});
    end
    @(negedge clk);
    bus.wr_valid = 1'b0;
    rst = 1'b1;
    read_burst(14'h0020, 8, 0);
    for (int i = 0; i < 8; i++) begin
      logic [7:0] exp;
      exp = (i < 3) ? 8'hC0 + 8'(i) : 8'h50 + 8'(i);
      checks++;
      if (rbuf[i] !== exp) begin
        failures++;
        $display("FAIL reset_survive idx=%0d got=%02h required=%02h", i, rbuf[i], exp);
      end
    end
  endtask

  task automatic test_write_read();
    write_burst(14'h0010, 4, 8'hA1);
    read_burst(14'h0010, 4, 0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rbuf[i] !== 8'hA1 + 8'(i)) begin
        failures++;
        $display("FAIL wr_rd idx=%0d got=%02h required=%02h", i, rbuf[i], 8'hA1 + 8'(i));
      end
    end
    checks++;
    if (bus.wrap !== 1'b0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL wr_rd_flags wrap=%0b busy=%0b required 0 0", bus.wrap, bus.busy);
    end
  endtask

  task automatic test_wrap();
    write_burst(14'h3FFE, 4, 8'hB1);
    repeat (3) @(negedge clk);
    checks++;
    if (bus.wrap !== 1'b1) begin
      failures++;
      $display("FAIL wrap_set wrap=%0b required=1", bus.wrap);
    end
    read_burst(14'h3FFE, 1, 0);
    checks++;
    if (bus.wrap !== 1'b0 || rbuf[0] !== 8'hB1) begin
      failures++;
      $display("FAIL wrap_clear wrap=%0b data=%02h required wrap=0 data=b1", bus.wrap, rbuf[0]);
    end
    read_burst(14'h0000, 2, 0);
    checks++;
    if (rbuf[0] !== 8'hB3 || rbuf[1] !== 8'hB4) begin
      failures++;
      $display("FAIL wrap_low got=%02h,%02h required=b3,b4", rbuf[0], rbuf[1]);
    end
    read_burst(14'h3FFF, 2, 0);
    checks++;
    if (rbuf[0] !== 8'hB2 || rbuf[1] !== 8'hB3 || bus.wrap !== 1'b1) begin
      failures++;
      $display("FAIL wrap_read got=%02h,%02h wrap=%0b required=b2,b3 wrap=1", rbuf[0], rbuf[1], bus.wrap);
    end
  endtask

  task automatic test_read_stall();
    write_burst(14'h0040, 8, 8'h61);
    read_burst(14'h0040, 8, 1);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (rbuf[i] !== 8'h61 + 8'(i)) begin
        failures++;
        $display("FAIL rd_stall idx=%0d got=%02h required=%02h", i, rbuf[i], 8'h61 + 8'(i));
      end
    end
    @(negedge clk);
    checks++;
    if (bus.rd_valid !== 1'b0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL rd_stall_end vld=%0b busy=%0b required 0 0", bus.rd_valid, bus.busy);
    end
  endtask

  task automatic test_clear();
    int busy_cyc = 0;
    int bad = 0;
    write_burst(14'h0100, 2, 8'hEE);
    write_burst(14'h01FF, 2, 8'hDD);
    do_cmd(2'b10, 14'h0100, 8'd255);
    while (bus.busy && busy_cyc < 1000) begin @(negedge clk); busy_cyc++; end
    checks++;
    if (busy_cyc != 256) begin
      failures++;
      $display("FAIL clear_busy cycles=%0d required=256", busy_cyc);
    end
    read_burst(14'h0100, 256, 0);
    for (int i = 0; i < 256; i++) if (rbuf[i] !== 8'h00) bad++;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL clear_fill nonzero=%0d required=0", bad);
    end
    read_burst(14'h0200, 1, 0);
    checks++;
    if (rbuf[0] !== 8'hDE) begin
      failures++;
      $display("FAIL clear_bound got=%02h required=de", rbuf[0]);
    end
  endtask

  task automatic test_illegal_busy();
    write_burst(14'h0300, 2, 8'h5A);
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_op = 2'b11; bus.cmd_addr = 14'h0300; bus.cmd_len = 8'd1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    checks++;
    if (bus.err !== 1'b1 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL illegal_err err=%0b busy=%0b required 1 0", bus.err, bus.busy);
    end
    @(negedge clk);
    checks++;
    if (bus.err !== 1'b0) begin
      failures++;
      $display("FAIL illegal_pulse err=%0b required=0", bus.err);
    end
    do_cmd(2'b01, 14'h0300, 8'd1);
    bus.cmd_valid = 1'b1; bus.cmd_op = 2'b10; bus.cmd_addr = 14'h0300; bus.cmd_len = 8'd1;
    @(negedge clk);
    checks++;
    if (bus.cmd_ready !== 1'b0 || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL busy_block ready=%0b busy=%0b required 0 1", bus.cmd_ready, bus.busy);
    end
    write_beats(1, 8'h71, 3);
    bus.cmd_valid = 1'b0;
    write_beats(1, 8'h72, 2);
    read_burst(14'h0300, 2, 0);
    checks++;
    if (rbuf[0] !== 8'h71 || rbuf[1] !== 8'h72) begin
      failures++;
      $display("FAIL busy_data got=%02h,%02h required=71,72", rbuf[0], rbuf[1]);
    end
  endtask

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_op = 2'b00; bus.cmd_addr = '0; bus.cmd_len = '0;
    bus.wr_valid = 1'b0; bus.wr_data = '0; bus.rd_ready = 1'b0;
    test_reset();
    test_write_read();
    test_wrap();
    test_read_stall();
    test_clear();
    test_illegal_busy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
